// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
// byte_merge is sized for the widest supported word; callers cast to their own width.
package dp_ram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} dp_ram_state_t;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_clear_ctrl.sv
// Clear sequencer: zero-fills (INIT_VALUE-fills) the array after reset or on request
// and arbitrates the single array write port between the sequencer and the user.
module dp_ram_clear_ctrl
  import dp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  input  logic                    user_we,
  input  logic [ADDR_WIDTH-1:0]   user_addr,
  input  logic [DATA_WIDTH/8-1:0] user_be,
  input  logic [DATA_WIDTH-1:0]   user_wdata,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    busy
);

  dp_ram_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = user_addr;
    mem_be    = user_be;
    mem_wdata = user_wdata;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_be    = '1;
        mem_wdata = INIT_VALUE;
        if (cnt_q == '1) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        // A clear request in the same cycle as a user write drops the write.
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (user_we) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with per-byte write enables, write-first bypass,
// a 1- or 2-stage registered read path with valid, and a hardware clear sequencer.
module dual_port_ram_be
  import dp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 3,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  input  logic                    write_en_i,
  input  logic [ADDR_WIDTH-1:0]   write_addr_i,
  input  logic                    read_en_i,
  input  logic [ADDR_WIDTH-1:0]   read_addr_i,
  input  logic                    clear_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    data_valid_o,
  output logic                    busy_o
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int MEM_SIZE = 2 ** ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_W-1:0]       be
  );
    return DATA_WIDTH'(byte_merge(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w), MAX_BE_W'(be)));
  endfunction

  logic                  busy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BE_W-1:0]       mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  dp_ram_clear_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_i),
    .user_we    (write_en_i),
    .user_addr  (write_addr_i),
    .user_be    (byte_en_i),
    .user_wdata (data_i),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .busy       (busy)
  );

  assign busy_o = busy;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= merge_word(mem[mem_addr], mem_wdata, mem_be);
  end

  // Stage p0: read accept and write-first bypass against an accepted user write
  logic                  rd_acc_p0;
  logic                  bypass_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;

  assign rd_acc_p0  = read_en_i && !busy;
  assign bypass_p0  = mem_we && !busy && (write_addr_i == read_addr_i);
  assign rd_word_p0 = bypass_p0 ? merge_word(mem[read_addr_i], data_i, byte_en_i)
                                : mem[read_addr_i];

  // Stage p1: registered read data
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc_p0;
      if (rd_acc_p0) data_p1 <= rd_word_p0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Stage p2: plain output register
      logic                  vld_p2;
      logic [DATA_WIDTH-1:0] data_p2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) data_p2 <= data_p1;
        end
      end

      assign data_o       = data_p2;
      assign data_valid_o = vld_p2;
    end else begin : g_lat1
      assign data_o       = data_p1;
      assign data_valid_o = vld_p1;
    end
  endgenerate

endmodule
